ts_window_z_math_multi: RTL and testbench

Multi-channel, pipelined successor to the single-channel z-window adder. Per channel, it adds the inner-layer stub z to both the lower and upper window offsets from the parameter LUTs. Results are optionally clamped to the physical z range. It flags empty windows and counts windows produced per channel. It sits between the window LUT readout and the outer-layer stub matcher in the track-seed path.

---
 rtl/ts_window_z_math_multi_pkg.sv | 30 +++
 rtl/ts_window_z_math_multi_if.sv | 44 ++++
 rtl/ts_window_z_bound.sv | 46 ++++
 rtl/ts_window_z_math_multi.sv | 127 ++++++++++++
 tb/tb_ts_window_z_math_multi.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_window_z_math_multi_pkg.sv
// ---------------------------------------------------------------------------
// ts_window_z_math_multi_pkg
// Shared definitions for the multi-channel z-window adder.
//   - Default stub z width and window offset width
//   - Default physical z limits of the detector
//   - clamp_signed(): signed clamp helper used by ts_window_z_bound
// ---------------------------------------------------------------------------
package ts_window_z_math_multi_pkg;

    // Stub z and window offset widths as delivered by the upstream readout
    localparam int STUB_Z_PHY_BITS   = 12;
    localparam int WINDOW_Z_DAT_BITS = 8;

    // Physical z range of the detector, in stub z units
    localparam int Z_MIN_DEFAULT = -2048;
    localparam int Z_MAX_DEFAULT = 2047;

    // Clamp a signed value into [lo_lim, hi_lim]
    function automatic int clamp_signed(input int value, input int lo_lim, input int hi_lim);
        int result;
        result = value;
        if (value < lo_lim) begin
            result = lo_lim;
        end else if (value > hi_lim) begin
            result = hi_lim;
        end
        return result;
    endfunction

endpackage

// File: rtl/ts_window_z_math_multi_if.sv
// ---------------------------------------------------------------------------
// ts_window_z_math_multi_if
// Bundles the per-channel data path of ts_window_z_math_multi.
//   in_valid  [NCH]          per-channel input qualifier
//   stub_dat  [NCH*ZBITS]    signed stub z, channel c at [c*ZBITS +: ZBITS]
//   z_lo_off  [NCH*OFFBITS]  signed lower-boundary offset
//   z_hi_off  [NCH*OFFBITS]  signed upper-boundary offset
//   cnt_clr                  clear all window counters
//   out_valid [NCH]          per-channel result qualifier
//   win_lo    [NCH*ZBITS]    signed lower window boundary
//   win_hi    [NCH*ZBITS]    signed upper window boundary
//   win_empty [NCH]          window is empty (lo > hi)
//   win_cnt   [NCH*CNTBITS]  saturating count of non-empty windows
// master: the producer side (LUT readout / bench); slave: the window adder.
// ---------------------------------------------------------------------------
interface ts_window_z_math_multi_if #(
    parameter int NCH     = 4,
    parameter int ZBITS   = 12,
    parameter int OFFBITS = 8,
    parameter int CNTBITS = 16
);

    logic [NCH-1:0]         in_valid;
    logic [NCH*ZBITS-1:0]   stub_dat;
    logic [NCH*OFFBITS-1:0] z_lo_off;
    logic [NCH*OFFBITS-1:0] z_hi_off;
    logic                   cnt_clr;
    logic [NCH-1:0]         out_valid;
    logic [NCH*ZBITS-1:0]   win_lo;
    logic [NCH*ZBITS-1:0]   win_hi;
    logic [NCH-1:0]         win_empty;
    logic [NCH*CNTBITS-1:0] win_cnt;

    modport master (
        output in_valid, stub_dat, z_lo_off, z_hi_off, cnt_clr,
        input  out_valid, win_lo, win_hi, win_empty, win_cnt
    );

    modport slave (
        input  in_valid, stub_dat, z_lo_off, z_hi_off, cnt_clr,
        output out_valid, win_lo, win_hi, win_empty, win_cnt
    );

endinterface

// File: rtl/ts_window_z_bound.sv
// ---------------------------------------------------------------------------
// ts_window_z_bound
// One channel, one window boundary: stub z + offset, reduced back to ZBITS.
// Purely combinational.
//   stub   [ZBITS]    signed stub z
//   off    [OFFBITS]  signed window offset
//   bound  [ZBITS]    signed boundary
// Build option TS_WINDOW_Z_SAT_EN: when defined the sum is clamped to
// [ZMIN, ZMAX]; otherwise it wraps to ZBITS like the legacy adder.
// ---------------------------------------------------------------------------
module ts_window_z_bound
    import ts_window_z_math_multi_pkg::*;
#(
    parameter int ZBITS   = STUB_Z_PHY_BITS,
    parameter int OFFBITS = WINDOW_Z_DAT_BITS,
    parameter int ZMIN    = Z_MIN_DEFAULT,
    parameter int ZMAX    = Z_MAX_DEFAULT
) (
    input  logic signed [ZBITS-1:0]   stub,
    input  logic signed [OFFBITS-1:0] off,
    output logic signed [ZBITS-1:0]   bound
);

    logic signed [ZBITS:0] stub_ext;
    logic signed [ZBITS:0] off_ext;
    logic signed [ZBITS:0] sum;

    // One extra bit holds any stub + offset without overflow
    always_comb begin
        stub_ext = {stub[ZBITS-1], stub};
        off_ext  = {{(ZBITS + 1 - OFFBITS){off[OFFBITS-1]}}, off};
        sum      = stub_ext + off_ext;
    end

`ifdef TS_WINDOW_Z_SAT_EN
    assign bound = ZBITS'(clamp_signed(int'(sum), ZMIN, ZMAX));
`else
    // Wrap: the carry bit and the z limits play no part in this build
    logic unused_carry;
    localparam int UNUSED_LIMIT_SPAN = ZMAX - ZMIN;

    assign bound        = sum[ZBITS-1:0];
    assign unused_carry = sum[ZBITS];
`endif

endmodule

// File: rtl/ts_window_z_math_multi.sv
// ---------------------------------------------------------------------------
// ts_window_z_math_multi
// Multi-channel, pipelined z-window adder. For every channel the stub z is
// added to the lower and upper window offsets; the result is flagged empty
// when lo > hi, delayed to LAT cycles total, and non-empty windows are
// counted per channel with a saturating counter.
//   clk   processing clock
//   rst   synchronous reset, active-high (clears every flop)
//   bus   ts_window_z_math_multi_if.slave (inputs, results, counters)
// Build option TS_WINDOW_Z_SAT_EN: clamp sums to [ZMIN, ZMAX] instead of
// wrapping them to ZBITS.
// ---------------------------------------------------------------------------
module ts_window_z_math_multi
    import ts_window_z_math_multi_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ZBITS   = STUB_Z_PHY_BITS,
    parameter int OFFBITS = WINDOW_Z_DAT_BITS,
    parameter int LAT     = 2,
    parameter int ZMIN    = Z_MIN_DEFAULT,
    parameter int ZMAX    = Z_MAX_DEFAULT,
    parameter int CNTBITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ts_window_z_math_multi_if.slave    bus
);

    logic [NCH-1:0][ZBITS-1:0] next_lo;
    logic [NCH-1:0][ZBITS-1:0] next_hi;
    logic [NCH-1:0]            next_empty;

    // Pipeline stage 0 is the arithmetic register; later stages are delay
    logic [NCH-1:0]            pipe_valid [LAT];
    logic [NCH-1:0][ZBITS-1:0] pipe_lo    [LAT];
    logic [NCH-1:0][ZBITS-1:0] pipe_hi    [LAT];
    logic [NCH-1:0]            pipe_empty [LAT];

    logic [NCH-1:0][CNTBITS-1:0] cnt;

    // Two boundary adders per channel plus the signed empty test
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [ZBITS-1:0] lo_b;
        logic signed [ZBITS-1:0] hi_b;

        ts_window_z_bound #(
            .ZBITS   (ZBITS),
            .OFFBITS (OFFBITS),
            .ZMIN    (ZMIN),
            .ZMAX    (ZMAX)
        ) u_lo (
            .stub  (bus.stub_dat[c*ZBITS +: ZBITS]),
            .off   (bus.z_lo_off[c*OFFBITS +: OFFBITS]),
            .bound (lo_b)
        );

        ts_window_z_bound #(
            .ZBITS   (ZBITS),
            .OFFBITS (OFFBITS),
            .ZMIN    (ZMIN),
            .ZMAX    (ZMAX)
        ) u_hi (
            .stub  (bus.stub_dat[c*ZBITS +: ZBITS]),
            .off   (bus.z_hi_off[c*OFFBITS +: OFFBITS]),
            .bound (hi_b)
        );

        assign next_lo[c]    = lo_b;
        assign next_hi[c]    = hi_b;
        assign next_empty[c] = (lo_b > hi_b);
    end

    // Data only moves with its valid bit, so each channel's outputs keep
    // the last delivered window while that channel is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                pipe_valid[s] <= '0;
                pipe_lo[s]    <= '0;
                pipe_hi[s]    <= '0;
                pipe_empty[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= bus.in_valid;
            for (int c = 0; c < NCH; c++) begin
                if (bus.in_valid[c]) begin
                    pipe_lo[0][c]    <= next_lo[c];
                    pipe_hi[0][c]    <= next_hi[c];
                    pipe_empty[0][c] <= next_empty[c];
                end
            end
            for (int s = 1; s < LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                for (int c = 0; c < NCH; c++) begin
                    if (pipe_valid[s-1][c]) begin
                        pipe_lo[s][c]    <= pipe_lo[s-1][c];
                        pipe_hi[s][c]    <= pipe_hi[s-1][c];
                        pipe_empty[s][c] <= pipe_empty[s-1][c];
                    end
                end
            end
        end
    end

    // Count emitted non-empty windows; clear wins over increment and the
    // counter sticks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.cnt_clr) begin
                    cnt[c] <= '0;
                end else if (pipe_valid[LAT-1][c] && !pipe_empty[LAT-1][c] && !(&cnt[c])) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = pipe_valid[LAT-1];
    assign bus.win_lo    = pipe_lo[LAT-1];
    assign bus.win_hi    = pipe_hi[LAT-1];
    assign bus.win_empty = pipe_empty[LAT-1];
    assign bus.win_cnt   = cnt;

endmodule

// File: tb/tb_ts_window_z_math_multi.sv
// ---------------------------------------------------------------------------
// tb_ts_window_z_math_multi
// Bench for ts_window_z_math_multi. dut_a is the default 4-channel, LAT=2
// build with a scoreboard-driven monitor; dut_b is a 1-channel, LAT=1,
// 4-bit counter build used for counter saturation and clear.
// Honours TS_WINDOW_Z_SAT_EN in its reference model.
// ---------------------------------------------------------------------------
module tb_ts_window_z_math_multi;
    import ts_window_z_math_multi_pkg::*;

    localparam int NCH     = 4;
    localparam int ZBITS   = 12;
    localparam int OFFBITS = 8;
    localparam int LAT     = 2;
    localparam int CNTBITS = 16;
    localparam int B_CNTBITS = 4;
    localparam int CNT_MAX = 65535;

    typedef struct {
        int lo;
        int hi;
        int empty;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   check_cnt = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   cnt_model [NCH];
    exp_t sb [NCH][$];

    ts_window_z_math_multi_if #(.NCH(NCH), .ZBITS(ZBITS), .OFFBITS(OFFBITS), .CNTBITS(CNTBITS)) bus_a ();
    ts_window_z_math_multi_if #(.NCH(1), .ZBITS(ZBITS), .OFFBITS(OFFBITS), .CNTBITS(B_CNTBITS)) bus_b ();

    ts_window_z_math_multi #(
        .NCH(NCH), .ZBITS(ZBITS), .OFFBITS(OFFBITS), .LAT(LAT),
        .ZMIN(-2048), .ZMAX(2047), .CNTBITS(CNTBITS)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ts_window_z_math_multi #(
        .NCH(1), .ZBITS(ZBITS), .OFFBITS(OFFBITS), .LAT(1),
        .ZMIN(-2048), .ZMAX(2047), .CNTBITS(B_CNTBITS)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference boundary: integer sum, then clamp or two's-complement wrap
    function automatic int model_bound(input int stub, input int off);
        int s;
        s = stub + off;
`ifdef TS_WINDOW_Z_SAT_EN
        if (s < -2048) s = -2048;
        if (s > 2047) s = 2047;
`else
        if (s > 2047) s = s - 4096;
        else if (s < -2048) s = s + 4096;
`endif
        return s;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one channel of dut_a for the coming edge and queue its result
    task automatic applyStimulus(input int ch, input int stub, input int lo_off, input int hi_off);
        exp_t e;
        bus_a.in_valid[ch] = 1'b1;
        bus_a.stub_dat[ch*ZBITS +: ZBITS]     = ZBITS'(stub);
        bus_a.z_lo_off[ch*OFFBITS +: OFFBITS] = OFFBITS'(lo_off);
        bus_a.z_hi_off[ch*OFFBITS +: OFFBITS] = OFFBITS'(hi_off);
        e.lo    = model_bound(stub, lo_off);
        e.hi    = model_bound(stub, hi_off);
        e.empty = (e.lo > e.hi) ? 1 : 0;
        e.due   = edge_cnt + LAT;
        sb[ch].push_back(e);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
        bus_a.in_valid = '0;
        bus_a.cnt_clr  = 1'b0;
        bus_b.in_valid = '0;
        bus_b.cnt_clr  = 1'b0;
    endtask

    // Monitor for dut_a: pop the scoreboard on every valid output, flag
    // early/late/spurious results, and track the expected counters
    always @(negedge clk) begin : mon_a
        exp_t e;
        int   counted;
        if (edge_cnt > 0) begin
            for (int c = 0; c < NCH; c++) begin
                counted = 0;
                if (bus_a.out_valid[c]) begin
                    if (sb[c].size() == 0) begin
                        checkOutput($sformatf("spurious_valid_ch%0d", c), int'(bus_a.out_valid[c]), 0);
                    end else begin
                        e = sb[c].pop_front();
                        checkOutput($sformatf("latency_ch%0d", c), edge_cnt, e.due);
                        checkOutput($sformatf("win_lo_ch%0d", c), int'($signed(bus_a.win_lo[c*ZBITS +: ZBITS])), e.lo);
                        checkOutput($sformatf("win_hi_ch%0d", c), int'($signed(bus_a.win_hi[c*ZBITS +: ZBITS])), e.hi);
                        checkOutput($sformatf("win_empty_ch%0d", c), int'(bus_a.win_empty[c]), e.empty);
                        counted = (e.empty == 0) ? 1 : 0;
                    end
                end else if (sb[c].size() > 0 && sb[c][0].due <= edge_cnt) begin
                    e = sb[c].pop_front();
                    checkOutput($sformatf("missing_valid_ch%0d", c), int'(bus_a.out_valid[c]), 1);
                end
                checkOutput($sformatf("win_cnt_ch%0d", c), int'(bus_a.win_cnt[c*CNTBITS +: CNTBITS]), cnt_model[c]);
                if (rst || bus_a.cnt_clr) begin
                    cnt_model[c] = 0;
                end else if (counted == 1 && cnt_model[c] != CNT_MAX) begin
                    cnt_model[c] = cnt_model[c] + 1;
                end
                if (rst) sb[c].delete();
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) cnt_model[c] = 0;
        rst = 1'b1;
        bus_a.in_valid = '0;
        bus_a.stub_dat = '0;
        bus_a.z_lo_off = '0;
        bus_a.z_hi_off = '0;
        bus_a.cnt_clr  = 1'b0;
        bus_b.in_valid = '0;
        bus_b.stub_dat = '0;
        bus_b.z_lo_off = '0;
        bus_b.z_hi_off = '0;
        bus_b.cnt_clr  = 1'b0;
        repeat (3) waitCycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", int'(bus_a.out_valid), 0);
        checkOutput("rst_win_lo", int'(bus_a.win_lo), 0);
        checkOutput("rst_win_hi", int'(bus_a.win_hi), 0);
        checkOutput("rst_win_empty", int'(bus_a.win_empty), 0);
        checkOutput("rst_b_out_valid", int'(bus_b.out_valid), 0);
        checkOutput("rst_b_win_cnt", int'(bus_b.win_cnt), 0);
        waitCycle();

        // Basic window, then the saturation/wrap case and empty windows
        applyStimulus(0, 100, -20, 30);
        waitCycle();
        applyStimulus(1, 2040, -5, 20);
        waitCycle();
        applyStimulus(2, 0, 10, -10);
        waitCycle();
        applyStimulus(2, 0, 5, 5);
        waitCycle();

        // Zero offsets, most negative offset, bottom of the z range
        applyStimulus(3, -777, 0, 0);
        applyStimulus(0, 5, -128, 127);
        applyStimulus(1, -2048, -128, 0);
        applyStimulus(2, 2047, 127, 127);
        waitCycle();
        repeat (3) waitCycle();

        // Back-to-back streaming on all channels
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < NCH; c++) begin
                applyStimulus(c, int'($urandom_range(4095, 0)) - 2048,
                              int'($urandom_range(255, 0)) - 128,
                              int'($urandom_range(255, 0)) - 128);
            end
            waitCycle();
        end
        repeat (3) waitCycle();

        // Counter clear on the same cycle as a valid non-empty output
        applyStimulus(0, 10, -1, 1);
        waitCycle();
        waitCycle();
        bus_a.cnt_clr = 1'b1;
        waitCycle();
        @(negedge clk);
        checkOutput("clr_win_cnt_ch0", int'(bus_a.win_cnt[0 +: CNTBITS]), 0);
        checkOutput("clr_win_cnt_ch3", int'(bus_a.win_cnt[3*CNTBITS +: CNTBITS]), 0);
        waitCycle();

        // Reset while two results are in flight
        applyStimulus(0, 50, -1, 1);
        applyStimulus(1, 60, -1, 1);
        waitCycle();
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", int'(bus_a.out_valid), 0);
        checkOutput("midrst_win_lo", int'(bus_a.win_lo), 0);
        checkOutput("midrst_win_hi", int'(bus_a.win_hi), 0);
        checkOutput("midrst_win_empty", int'(bus_a.win_empty), 0);
        checkOutput("midrst_win_cnt", int'(bus_a.win_cnt), 0);
        waitCycle();
        repeat (3) waitCycle();
        applyStimulus(3, -300, -4, 4);
        waitCycle();
        repeat (3) waitCycle();

        // dut_b: 20 non-empty windows into a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            bus_b.in_valid = 1'b1;
            bus_b.stub_dat = ZBITS'(i * 10);
            bus_b.z_lo_off = OFFBITS'(-1);
            bus_b.z_hi_off = OFFBITS'(1);
            waitCycle();
        end
        waitCycle();
        waitCycle();
        @(negedge clk);
        checkOutput("b_cnt_saturated", int'(bus_b.win_cnt), 15);
        waitCycle();

        // dut_b: single-cycle latency, then clear on a valid output
        bus_b.in_valid = 1'b1;
        bus_b.stub_dat = ZBITS'(300);
        bus_b.z_lo_off = OFFBITS'(-3);
        bus_b.z_hi_off = OFFBITS'(4);
        waitCycle();
        @(negedge clk);
        checkOutput("b_lat1_valid", int'(bus_b.out_valid), 1);
        checkOutput("b_lat1_lo", int'($signed(bus_b.win_lo)), 297);
        checkOutput("b_lat1_hi", int'($signed(bus_b.win_hi)), 304);
        checkOutput("b_lat1_empty", int'(bus_b.win_empty), 0);
        bus_b.cnt_clr = 1'b1;
        waitCycle();
        @(negedge clk);
        checkOutput("b_clr_cnt", int'(bus_b.win_cnt), 0);
        checkOutput("b_idle_valid", int'(bus_b.out_valid), 0);
        waitCycle();
        bus_b.in_valid = 1'b1;
        waitCycle();
        waitCycle();
        @(negedge clk);
        checkOutput("b_cnt_after_clr", int'(bus_b.win_cnt), 1);
        waitCycle();

        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("sb_drained_ch%0d", c), sb[c].size(), 0);
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
